// File: rtl/data_mem_responder.sv
// Data-memory responder for the single-cycle core: byte/half/word stores on the clock edge,
// combinational byte-aligned reads, a post-reset zero-fill sequencer, and store bookkeeping.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] memory_address,
  input  logic [31:0] data_to_write,
  input  logic [2:0]  func3,
  input  logic        write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        misaligned,
  output logic [31:0] store_count
);

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   clear_idx, clear_idx_nxt;
  logic [31:0]        mem [DEPTH_WORDS];

  logic [IDX_W-1:0]   word_idx;
  logic [1:0]         lane;
  logic               in_range;
  logic               func_ok, align_ok;
  logic [3:0]         store_be;
  logic [31:0]        store_wdata;
  logic               store_req, store_bad, store_commit;
  logic               mem_we;
  logic [IDX_W-1:0]   mem_idx;
  logic [3:0]         mem_be;
  logic [31:0]        mem_wdata;
  logic [31:0]        rd_word;

  assign word_idx = memory_address[IDX_W+1:2];
  assign lane     = memory_address[1:0];
  assign in_range = ~|memory_address[31:IDX_W+2];

  // Store decode: lane enables plus data replicated across lanes so any lane picks its byte.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    func_ok     = 1'b1;
    align_ok    = 1'b1;
    store_be    = 4'b0000;
    store_wdata = '0;
    case (func3)
      3'b000: begin
        store_be    = 4'b0001 << lane;
        store_wdata = {4{data_to_write[7:0]}};
      end
      3'b001: begin
        align_ok    = ~lane[0];
        store_be    = lane[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{data_to_write[15:0]}};
      end
      3'b010: begin
        align_ok    = (lane == 2'b00);
        store_be    = 4'b1111;
        store_wdata = data_to_write;
      end
      default: func_ok = 1'b0;
    endcase
  end

  assign store_req    = (state == IDLE) && write_data && !rst;
  assign store_bad    = store_req && !(func_ok && align_ok);
  assign store_commit = store_req && func_ok && align_ok && in_range;

  always_comb begin
    state_nxt     = state;
    clear_idx_nxt = clear_idx;
    case (state)
      CLEAR: begin
        clear_idx_nxt = clear_idx + 1'b1;
        if (clear_idx == IDX_W'(DEPTH_WORDS - 1)) state_nxt = IDLE;
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clear_idx   <= '0;
      store_count <= '0;
      misaligned  <= 1'b0;
    end else begin
      state     <= state_nxt;
      clear_idx <= clear_idx_nxt;
      if (store_commit) store_count <= store_count + 32'd1;
      if (store_bad)    misaligned  <= 1'b1;
    end
  end

  // Single write port shared by the clear sequencer and committed stores.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = word_idx;
    mem_be    = store_be;
    mem_wdata = store_wdata;
    if (state == CLEAR && !rst) begin
      mem_we    = 1'b1;
      mem_idx   = clear_idx;
      mem_be    = 4'b1111;
      mem_wdata = '0;
    end else if (store_commit) begin
      mem_we = 1'b1;
    end
  end

  // NOTE: the array has no reset branch; the clear sequencer zero-fills it, keeping it a plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  assign ready     = (state == IDLE) && !rst;
  assign rd_word   = mem[word_idx];
  assign read_data = (ready && in_range) ? (rd_word >> {lane, 3'b000}) : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder: clear timing, store widths,
// misaligned/out-of-range rejection, same-cycle read/write and back-to-back stores.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] memory_address;
  logic [31:0] data_to_write;
  logic [2:0]  func3;
  logic        write_data;
  logic [31:0] read_data;
  logic        ready;
  logic        misaligned;
  logic [31:0] store_count;

  int n_checks = 0;
  int n_fail   = 0;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .IDX_W(10)) dut (
    .clk            (clk),
    .rst            (rst),
    .memory_address (memory_address),
    .data_to_write  (data_to_write),
    .func3          (func3),
    .write_data     (write_data),
    .read_data      (read_data),
    .ready          (ready),
    .misaligned     (misaligned),
    .store_count    (store_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] f3);
    memory_address = addr;
    data_to_write  = data;
    func3          = f3;
    write_data     = 1'b1;
    step();
    write_data     = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    memory_address = addr;
    #1;
    check(tag, read_data, exp);
  endtask

  int cnt;

  initial begin
    rst = 1'b1; memory_address = '0; data_to_write = '0; func3 = 3'b010; write_data = 1'b0;
    @(negedge clk);
    step(); step();
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_count", store_count, 32'd0);
    check("rst_misaligned", 32'(misaligned), 32'd0);

    // First clear, interrupted by reset after 500 cycles.
    rst = 1'b0;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 500) begin cnt++; step(); end
    check("clear1_ready_at_500", 32'(ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Second clear with a word store held active throughout; it must be dropped.
    memory_address = 32'h0; data_to_write = 32'hFFFF_FFFF; func3 = 3'b010; write_data = 1'b1;
    cnt = 0;
    while (ready !== 1'b1 && cnt < 3 * DEPTH) begin cnt++; step(); end
    write_data = 1'b0;
    check("clear2_cycles", 32'(cnt), 32'(DEPTH));
    read_chk("read_0_after_clear", 32'h0, 32'h0);
    read_chk("read_ffc_after_clear", 32'hFFC, 32'h0);
    check("count_after_clear", store_count, 32'd0);
    check("flag_after_clear", 32'(misaligned), 32'd0);

    // Word, byte, half stores.
    store(32'h10, 32'hDEAD_BEEF, 3'b010);
    read_chk("sw_read", 32'h10, 32'hDEAD_BEEF);
    store(32'h12, 32'h0000_0055, 3'b000);
    read_chk("sb_read_word", 32'h10, 32'hDE55_BEEF);
    read_chk("sb_read_off2", 32'h12, 32'h0000_DE55);
    read_chk("sb_read_off3", 32'h13, 32'h0000_00DE);
    store(32'h10, 32'hFFFF_1234, 3'b001);
    read_chk("sh_read", 32'h10, 32'hDE55_1234);
    check("count_3", store_count, 32'd3);

    // Out of range dropped without flag; top word committed.
    store(32'(DEPTH * 4), 32'h1234_5678, 3'b010);
    read_chk("oor_read", 32'(DEPTH * 4), 32'h0);
    check("oor_count", store_count, 32'd3);
    check("oor_no_flag", 32'(misaligned), 32'd0);
    store(32'(DEPTH * 4 - 4), 32'hA5A5_A5A5, 3'b010);
    read_chk("top_word_read", 32'(DEPTH * 4 - 4), 32'hA5A5_A5A5);
    check("top_word_count", store_count, 32'd4);

    // Misaligned and invalid stores.
    store(32'h21, 32'hCAFE_F00D, 3'b010);
    read_chk("mis_sw_mem", 32'h20, 32'h0);
    check("mis_sw_flag", 32'(misaligned), 32'd1);
    check("mis_sw_count", store_count, 32'd4);
    store(32'h23, 32'hBEEF_BEEF, 3'b001);
    read_chk("mis_sh_mem", 32'h20, 32'h0);
    check("mis_sh_flag", 32'(misaligned), 32'd1);
    store(32'h24, 32'h7777_7777, 3'b011);
    read_chk("bad_f3_mem", 32'h24, 32'h0);
    check("bad_f3_count", store_count, 32'd4);

    // Same-cycle read and write: old data before the edge, new after.
    memory_address = 32'h40; data_to_write = 32'h1111_1111; func3 = 3'b010; write_data = 1'b1;
    #1;
    check("rw_pre_edge", read_data, 32'h0);
    step();
    write_data = 1'b0;
    read_chk("rw_post_edge", 32'h40, 32'h1111_1111);
    check("rw_count", store_count, 32'd5);

    // Four back-to-back word stores.
    func3 = 3'b010; write_data = 1'b1;
    for (int i = 0; i < 4; i++) begin
      memory_address = 32'h50 + 32'(4 * i);
      data_to_write  = 32'hC0DE_0000 + 32'(i);
      step();
    end
    write_data = 1'b0;
    check("b2b_count", store_count, 32'd9);
    read_chk("b2b_read0", 32'h50, 32'hC0DE_0000);
    read_chk("b2b_read3", 32'h5C, 32'hC0DE_0003);

    // Reads are masked while reset is asserted.
    rst = 1'b1;
    read_chk("rst_read_masked", 32'h10, 32'h0);
    check("rst_ready_low", 32'(ready), 32'd0);
    step();
    check("rst_clears_count", store_count, 32'd0);
    check("rst_clears_flag", 32'(misaligned), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
